// File: rtl/maf_pkg.sv
// Shared types and constants for the moving-average stream filter.
package maf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } maf_state_t;

   localparam int DEFAULT_EOS = 255;

   // Running sum of M = 2**log2_m samples never exceeds data_w + log2_m bits.
   function automatic int sum_width(input int data_w, input int log2_m);
      return data_w + log2_m;
   endfunction

endpackage

// File: rtl/maf_window.sv
// M-slot ring buffer with running sum; y is the updated average for the sample on x.
module maf_window
   import maf_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LOG2_M = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              seed,
   input  logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] y
);

   localparam int M     = 2 ** LOG2_M;
   localparam int SUM_W = sum_width(DATA_W, LOG2_M);

   logic [DATA_W-1:0] ring [M];
   logic [LOG2_M-1:0] ptr;
   logic [SUM_W-1:0]  sum;
   logic [SUM_W-1:0]  sum_next;
   logic [SUM_W-1:0]  x_ext;
   logic [SUM_W-1:0]  oldest_ext;

   // A seeded first sample behaves as if the whole window already held x.
   always_comb begin
      x_ext      = SUM_W'(x);
      oldest_ext = SUM_W'(ring[ptr]);
      if (seed) begin
         sum_next = x_ext << LOG2_M;
      end else begin
         sum_next = sum + x_ext - oldest_ext;
      end
      y = DATA_W'(sum_next >> LOG2_M);
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int i = 0; i < M; i++) begin
            ring[i] <= '0;
         end
         ptr <= '0;
         sum <= '0;
      end else if (load) begin
         if (seed) begin
            for (int i = 0; i < M; i++) begin
               ring[i] <= x;
            end
         end else begin
            ring[ptr] <= x;
         end
         ptr <= ptr + 1'b1;
         sum <= sum_next;
      end
   end

endmodule

// File: rtl/moving_avg_stream.sv
// Frame-based streaming boxcar filter: pulls ADC samples, emits one M-tap average per sample.
module moving_avg_stream
   import maf_pkg::*;
#(
   parameter int                DATA_W  = 8,
   parameter int                LOG2_M  = 1,
   parameter int                LEN_W   = 8,
   parameter bit                EOS_EN  = 1'b1,
   parameter logic [DATA_W-1:0] EOS_VAL = DATA_W'(DEFAULT_EOS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              warm_mode,
   output logic              adc_req,
   input  logic              adc_rdy,
   input  logic [DATA_W-1:0] adc_dat,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  out_count,
   output maf_state_t        state_dbg
);

   // Handshakes: a transfer happens on a rising edge where the offering side (adc_req /
   // out_valid) and the accepting side (adc_rdy / out_ready) are both high. out_valid,
   // out_data and out_last stay stable until accepted; adc_rdy without adc_req is ignored.

   maf_state_t        state;
   maf_state_t        state_next;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  fetched;
   logic              warm_q;
   logic              start_ok;
   logic              drained;
   logic              out_hs;
   logic              xfer;
   logic              is_eos;
   logic              sample_xfer;
   logic              eos_xfer;
   logic              seed;
   logic [DATA_W-1:0] y;

   assign start_ok    = start && (state == IDLE);
   assign out_hs      = out_valid && out_ready;
   assign drained     = !out_valid || out_ready;
   assign xfer        = adc_req && adc_rdy;
   assign is_eos      = EOS_EN && (adc_dat == EOS_VAL);
   assign sample_xfer = xfer && !is_eos;
   assign eos_xfer    = xfer && is_eos;
   assign seed        = warm_q && (fetched == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start) state_next = (len == '0) ? DONE : FETCH;
         FETCH: if (eos_xfer || ((fetched == len_q) && drained)) state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      adc_req   = (state == FETCH) && (fetched != len_q) && drained;
      busy      = (state == FETCH);
      done      = (state == DONE);
      state_dbg = state;
   end

   // EOS can only be accepted while the output register is empty or draining this edge,
   // so the previous sample has always left by then and never needs a late out_last.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q     <= '0;
         warm_q    <= 1'b0;
         fetched   <= '0;
         out_count <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (start_ok) begin
         len_q     <= len;
         warm_q    <= warm_mode;
         fetched   <= '0;
         out_count <= '0;
      end else begin
         if (out_hs) begin
            out_count <= out_count + 1'b1;
         end
         if (sample_xfer) begin
            fetched   <= fetched + 1'b1;
            out_valid <= 1'b1;
            out_data  <= y;
            out_last  <= ((fetched + 1'b1) == len_q);
         end else if (out_hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   maf_window #(
      .DATA_W (DATA_W),
      .LOG2_M (LOG2_M)
   ) u_window (
      .clk   (clk),
      .rst   (rst),
      .clear (start_ok),
      .load  (sample_xfer),
      .seed  (seed),
      .x     (adc_dat),
      .y     (y)
   );

endmodule

// File: tb/tb_moving_avg_stream.sv
// Directed bench: one DUT with M=4 and one with M=2 share stimulus; sel picks the one checked.
module tb_moving_avg_stream;
   import maf_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] len_in = 8'd0;
   logic       warm_mode = 1'b0;
   logic       adc_rdy = 1'b0;
   logic [7:0] adc_dat = 8'd0;
   logic       out_ready = 1'b1;
   logic       sel = 1'b1;

   logic a_adc_req, a_out_valid, a_out_last, a_busy, a_done;
   logic [7:0] a_out_data, a_out_count;
   maf_state_t a_state;
   logic b_adc_req, b_out_valid, b_out_last, b_busy, b_done;
   logic [7:0] b_out_data, b_out_count;
   maf_state_t b_state;

   logic obs_adc_req, obs_out_valid, obs_out_last, obs_busy, obs_done;
   logic [7:0] obs_out_data, obs_out_count;
   maf_state_t obs_state;

   assign obs_adc_req   = sel ? a_adc_req   : b_adc_req;
   assign obs_out_valid = sel ? a_out_valid : b_out_valid;
   assign obs_out_last  = sel ? a_out_last  : b_out_last;
   assign obs_busy      = sel ? a_busy      : b_busy;
   assign obs_done      = sel ? a_done      : b_done;
   assign obs_out_data  = sel ? a_out_data  : b_out_data;
   assign obs_out_count = sel ? a_out_count : b_out_count;
   assign obs_state     = sel ? a_state     : b_state;

   moving_avg_stream #(.DATA_W(8), .LOG2_M(2), .LEN_W(8), .EOS_EN(1'b1), .EOS_VAL(8'd255)) dut_m4 (
      .clk(clk), .rst(rst), .start(start), .len(len_in), .warm_mode(warm_mode),
      .adc_req(a_adc_req), .adc_rdy(adc_rdy), .adc_dat(adc_dat),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_last(a_out_last),
      .busy(a_busy), .done(a_done), .out_count(a_out_count), .state_dbg(a_state)
   );

   moving_avg_stream #(.DATA_W(8), .LOG2_M(1), .LEN_W(8), .EOS_EN(1'b1), .EOS_VAL(8'd255)) dut_m2 (
      .clk(clk), .rst(rst), .start(start), .len(len_in), .warm_mode(warm_mode),
      .adc_req(b_adc_req), .adc_rdy(adc_rdy), .adc_dat(adc_dat),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_last(b_out_last),
      .busy(b_busy), .done(b_done), .out_count(b_out_count), .state_dbg(b_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard
   logic [7:0] exp_q[$];
   logic       exp_last_q[$];
   logic [7:0] got_q[$];
   logic       got_last_q[$];
   logic [7:0] adc_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt, done_cyc, req_cnt, stall_req, stall_hold_bad, stall_valid_cyc;

   task automatic clear_sb();
      exp_q.delete(); exp_last_q.delete(); got_q.delete(); got_last_q.delete(); adc_q.delete();
      done_cnt = 0; done_cyc = 0; req_cnt = 0;
      stall_req = 0; stall_hold_bad = 0; stall_valid_cyc = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b0; adc_rdy = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_sb();
   endtask

   task automatic start_frame(input logic [7:0] l, input logic w);
      @(negedge clk);
      start = 1'b1; len_in = l; warm_mode = w;
   endtask

   // Drives ADC from adc_q and collects outputs until done or the cycle budget runs out.
   task automatic run_frame(input int max_cyc, input int stall_after, input int stall_len,
                            input int poke_cyc);
      int stall_left = 0;
      int n_out = 0;
      bit fin = 1'b0;
      bit prev_stall = 1'b0;
      logic [7:0] held = 8'd0;
      for (int cyc = 1; cyc <= max_cyc && !fin; cyc++) begin
         @(negedge clk);
         start = (cyc == poke_cyc);
         if (cyc == poke_cyc) begin
            len_in = 8'd1; warm_mode = 1'b1;
         end
         out_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         adc_rdy = (adc_q.size() > 0);
         adc_dat = adc_rdy ? adc_q[0] : 8'd0;
         #1;
         if (obs_adc_req) req_cnt++;
         if (!out_ready && obs_out_valid) begin
            stall_valid_cyc++;
            if (obs_adc_req) stall_req++;
            if (prev_stall && (obs_out_data !== held)) stall_hold_bad++;
            held = obs_out_data;
            prev_stall = 1'b1;
         end else begin
            prev_stall = 1'b0;
         end
         if (obs_adc_req && adc_rdy) void'(adc_q.pop_front());
         if (obs_out_valid && out_ready) begin
            got_q.push_back(obs_out_data);
            got_last_q.push_back(obs_out_last);
            n_out++;
            if (n_out == stall_after) stall_left = stall_len;
         end
         if (obs_done) begin
            done_cnt++; done_cyc = cyc; fin = 1'b1;
         end
      end
      start = 1'b0; adc_rdy = 1'b0; out_ready = 1'b1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
         if (obs_done) done_cnt++;
         if (obs_adc_req) req_cnt++;
      end
   endtask

   task automatic test_reset();
      sel = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (obs_adc_req !== 1'b0) begin n_bad++; $display("FAIL reset_adc_req: got %0d want 0", obs_adc_req); end
      n_cmp++; if (obs_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0d want 0", obs_out_valid); end
      n_cmp++; if (obs_out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %0d want 0", obs_out_last); end
      n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0d want 0", obs_busy); end
      n_cmp++; if (obs_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0d want 0", obs_done); end
      n_cmp++; if (obs_out_data !== 8'd0) begin n_bad++; $display("FAIL reset_out_data: got %0d want 0", obs_out_data); end
      n_cmp++; if (obs_out_count !== 8'd0) begin n_bad++; $display("FAIL reset_out_count: got %0d want 0", obs_out_count); end
      n_cmp++; if (obs_state !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", obs_state, IDLE); end
      rst = 1'b0;
   endtask

   task automatic test_zero_warm_m4(input logic w);
      sel = 1'b1;
      do_reset();
      adc_q = '{8'd4, 8'd8, 8'd12, 8'd16};
      if (w) exp_q = '{8'd4, 8'd5, 8'd7, 8'd10};
      else   exp_q = '{8'd1, 8'd3, 8'd6, 8'd10};
      exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
      start_frame(8'd4, w);
      run_frame(40, 0, 0, 0);
      idle_cycles(3);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL m4_w%0d_count: got %0d want %0d", w, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL m4_w%0d_data[%0d]: got %0d want %0d", w, i, got_q[i], exp_q[i]); end
         n_cmp++; if (got_last_q[i] !== exp_last_q[i]) begin n_bad++; $display("FAIL m4_w%0d_last[%0d]: got %0d want %0d", w, i, got_last_q[i], exp_last_q[i]); end
      end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL m4_w%0d_done_pulses: got %0d want 1", w, done_cnt); end
      n_cmp++; if (obs_out_count !== 8'd4) begin n_bad++; $display("FAIL m4_w%0d_out_count: got %0d want 4", w, obs_out_count); end
      n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL m4_w%0d_busy_after: got %0d want 0", w, obs_busy); end
   endtask

   task automatic test_backpressure();
      sel = 1'b0;
      do_reset();
      adc_q = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
      exp_q = '{8'd5, 8'd15, 8'd25, 8'd35, 8'd45, 8'd55};
      exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      start_frame(8'd6, 1'b0);
      run_frame(60, 2, 3, 0);
      idle_cycles(3);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
         n_cmp++; if (got_last_q[i] !== exp_last_q[i]) begin n_bad++; $display("FAIL bp_last[%0d]: got %0d want %0d", i, got_last_q[i], exp_last_q[i]); end
      end
      n_cmp++; if (stall_valid_cyc != 3) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d want 3", stall_valid_cyc); end
      n_cmp++; if (stall_req != 0) begin n_bad++; $display("FAIL bp_req_in_stall: got %0d want 0", stall_req); end
      n_cmp++; if (stall_hold_bad != 0) begin n_bad++; $display("FAIL bp_data_held: got %0d changes want 0", stall_hold_bad); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
      n_cmp++; if (obs_out_count !== 8'd6) begin n_bad++; $display("FAIL bp_out_count: got %0d want 6", obs_out_count); end
   endtask

   task automatic test_eos();
      sel = 1'b0;
      do_reset();
      adc_q = '{8'd10, 8'd20, 8'd255};
      exp_q = '{8'd5, 8'd15};
      exp_last_q = '{1'b0, 1'b0};
      start_frame(8'd8, 1'b0);
      run_frame(40, 0, 0, 0);
      idle_cycles(3);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL eos_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL eos_data[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
         n_cmp++; if (got_last_q[i] !== exp_last_q[i]) begin n_bad++; $display("FAIL eos_last[%0d]: got %0d want %0d", i, got_last_q[i], exp_last_q[i]); end
      end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL eos_done_pulses: got %0d want 1", done_cnt); end
      n_cmp++; if (obs_out_count !== 8'd2) begin n_bad++; $display("FAIL eos_out_count: got %0d want 2", obs_out_count); end
      n_cmp++; if (adc_q.size() != 0) begin n_bad++; $display("FAIL eos_consumed: got %0d left want 0", adc_q.size()); end
   endtask

   task automatic test_len_zero();
      sel = 1'b1;
      do_reset();
      adc_q = '{8'd7, 8'd9};
      start_frame(8'd0, 1'b0);
      run_frame(10, 0, 0, 0);
      idle_cycles(3);
      n_cmp++; if (done_cyc != 1) begin n_bad++; $display("FAIL len0_done_cycle: got %0d want 1", done_cyc); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL len0_done_pulses: got %0d want 1", done_cnt); end
      n_cmp++; if (req_cnt != 0) begin n_bad++; $display("FAIL len0_adc_req: got %0d cycles want 0", req_cnt); end
      n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL len0_outputs: got %0d want 0", got_q.size()); end
   endtask

   task automatic test_reset_mid_frame();
      sel = 1'b0;
      do_reset();
      adc_q = '{8'd10, 8'd20, 8'd30};
      start_frame(8'd8, 1'b0);
      run_frame(5, 0, 0, 0);
      n_cmp++; if (obs_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %0d want 1", obs_busy); end
      n_cmp++; if (obs_out_count !== 8'd3) begin n_bad++; $display("FAIL mid_count_before: got %0d want 3", obs_out_count); end
      n_cmp++; if (obs_out_data !== 8'd25) begin n_bad++; $display("FAIL mid_data_before: got %0d want 25", obs_out_data); end
      rst = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %0d want 0", obs_busy); end
      n_cmp++; if (obs_out_count !== 8'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", obs_out_count); end
      n_cmp++; if (obs_out_data !== 8'd0) begin n_bad++; $display("FAIL mid_rst_data: got %0d want 0", obs_out_data); end
      n_cmp++; if (obs_adc_req !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req: got %0d want 0", obs_adc_req); end
      n_cmp++; if (obs_state !== IDLE) begin n_bad++; $display("FAIL mid_rst_state: got %0d want %0d", obs_state, IDLE); end
      rst = 1'b0;
      clear_sb();
      adc_q = '{8'd40, 8'd60};
      exp_q = '{8'd20, 8'd50};
      exp_last_q = '{1'b0, 1'b1};
      start_frame(8'd2, 1'b0);
      run_frame(30, 0, 0, 2);
      idle_cycles(3);
      n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL clean_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_cmp++; if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL clean_data[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); end
         n_cmp++; if (got_last_q[i] !== exp_last_q[i]) begin n_bad++; $display("FAIL clean_last[%0d]: got %0d want %0d", i, got_last_q[i], exp_last_q[i]); end
      end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL clean_done_pulses: got %0d want 1", done_cnt); end
      n_cmp++; if (obs_out_count !== 8'd2) begin n_bad++; $display("FAIL clean_out_count: got %0d want 2", obs_out_count); end
   endtask

   initial begin
      test_reset();
      test_zero_warm_m4(1'b0);
      test_zero_warm_m4(1'b1);
      test_backpressure();
      test_eos();
      test_len_zero();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
